// File: rtl/instr_fetch_ctrl.sv
// Sequential instruction fetcher: fixed-latency read tracking, return FIFO, redirect flush.
// Optional perf counters are enabled with the INSTR_FETCH_CTRL_PERF_EN macro.
module instr_fetch_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           RD_LATENCY = 2,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_fetch_addr0_rd,
  output logic                  instr_fetch0_rd,
  input  logic [DATA_WIDTH-1:0] instr_fetch_data0_rd,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef INSTR_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned LAST  = RD_LATENCY - 1;

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic                  epoch_reg;

  logic                  pipe_live_reg  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_pc_reg    [RD_LATENCY];
  logic                  pipe_epoch_reg [RD_LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_cnt_reg;

  logic [CNT_W-1:0]      inflight_cnt;
  logic                  issue;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (pipe_live_reg[i]) inflight_cnt = inflight_cnt + CNT_W'(1);
    end
  end

  // Credits cover both in-flight reads and buffered words, so a return always has a slot.
  assign issue = rst_n && !redirect &&
                 ((SUM_W'(inflight_cnt) + SUM_W'(fifo_cnt_reg)) < SUM_W'(FIFO_DEPTH));

  assign instr_fetch0_rd      = issue;
  assign instr_fetch_addr0_rd = pc_reg;

  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_push  = pipe_live_reg[LAST] && (pipe_epoch_reg[LAST] == epoch_reg) && !redirect;
  assign fifo_pop   = !fifo_empty && instr_ready && !redirect;

  assign instr_valid = !fifo_empty && !redirect;
  assign instr_data  = fifo_empty ? '0 : fifo_data_mem[rd_ptr_reg];
  assign instr_pc    = fifo_empty ? '0 : fifo_pc_mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      epoch_reg <= 1'b0;
    end else if (redirect) begin
      pc_reg    <= redirect_pc & ~ADDR_WIDTH'(3);
      epoch_reg <= ~epoch_reg;
    end else if (issue) begin
      pc_reg    <= pc_reg + ADDR_WIDTH'(4);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            pipe_live_reg[0]  <= 1'b0;
            pipe_pc_reg[0]    <= '0;
            pipe_epoch_reg[0] <= 1'b0;
          end else begin
            pipe_live_reg[0]  <= issue;
            pipe_pc_reg[0]    <= pc_reg;
            pipe_epoch_reg[0] <= epoch_reg;
          end
        end
      end else begin : g_tail
        // A redirect kills every in-flight read so credits free up immediately.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            pipe_live_reg[gi]  <= 1'b0;
            pipe_pc_reg[gi]    <= '0;
            pipe_epoch_reg[gi] <= 1'b0;
          end else begin
            pipe_live_reg[gi]  <= pipe_live_reg[gi-1] && !redirect;
            pipe_pc_reg[gi]    <= pipe_pc_reg[gi-1];
            pipe_epoch_reg[gi] <= pipe_epoch_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_mem[wr_ptr_reg] <= instr_fetch_data0_rd;
      fifo_pc_mem[wr_ptr_reg]   <= pipe_pc_reg[LAST];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else if (redirect) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && !fifo_pop && (fifo_cnt_reg == CNT_W'(FIFO_DEPTH))));

`ifdef INSTR_FETCH_CTRL_PERF_EN
  // Tracks every issued read, live or killed, so discarded returns can be counted.
  logic pipe_busy_reg [RD_LATENCY];
  logic ret_drop;

  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_busy_reg[gi] <= 1'b0;
        else        pipe_busy_reg[gi] <= (gi == 0) ? issue : pipe_busy_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  assign ret_drop = pipe_busy_reg[LAST] && !fifo_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (fifo_pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (ret_drop) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule
